alu_vec_seq: RTL and testbench
==============================

// Module: alu_vec_seq
// PURPOSE
//  Lane-sequenced vector ALU. It applies one element-wise operation to two VECTOR_SIZE-bit vectors of ELEMENT-bit elements.
//  The vector is processed LANES elements per cycle over BEATS cycles, which trades area against latency.
//  It sits between the vector register file read port and the writeback stage, with valid/ready on both sides.
//  Adds optional signed saturation for ADD/SUB.
// PARAMETERS
//  VECTOR_SIZE  256  vector width in bits
//  ELEMENT      16   element width in bits; NUM_ELEM = VECTOR_SIZE/ELEMENT
//  LANES        4    elements computed per cycle; BEATS = NUM_ELEM/LANES
//  Elaboration must fail unless VECTOR_SIZE%ELEMENT==0 and NUM_ELEM%LANES==0.
// PORTS
//  clk        in   1            rising-edge clock
//  rst_n      in   1            asynchronous active-low reset
//  in_valid   in   1            operand request valid
//  in_ready   out  1            block can accept a request (high only in IDLE)
//  vectorA    in   VECTOR_SIZE  operand A, element i = bits [i*ELEMENT +: ELEMENT]
//  vectorB    in   VECTOR_SIZE  operand B, same packing
//  opcode     in   3            operation, encoding below
//  saturate   in   1            1 = signed-saturating ADD/SUB
//  out_valid  out  1            result valid
//  out_ready  in   1            consumer accepts result
//  result     out  VECTOR_SIZE  result vector, same packing
// BEHAVIOUR
//  Opcodes: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR,
//    101 SLL, 110 SRL (logical), 111 MUL (low ELEMENT bits of A*B, unsigned).
//  Shift amount = B element bits [$clog2(ELEMENT)-1:0]; upper bits are ignored.
//  ADD/SUB with saturate=0 wraps modulo 2^ELEMENT.
//  ADD/SUB with saturate=1 treats operands as two's complement. Overflow clamps to 2^(ELEMENT-1)-1 or -2^(ELEMENT-1).
//  saturate is ignored for all other opcodes.
//  FSM IDLE -> BUSY -> DONE -> IDLE:
//   IDLE: in_ready=1. On in_valid&&in_ready, register A, B, opcode and saturate, clear beat counter, go to BUSY.
//   BUSY: each cycle compute elements [beat*LANES +: LANES] and write them into the result register.
//     Elements not yet computed keep their old values.
//     beat increments each cycle. On the edge that processes beat==BEATS-1, go to DONE.
//   DONE: out_valid=1; result is held stable until out_valid&&out_ready, then go to IDLE.
//  Latency: request accepted at edge E. out_valid rises after edge E+BEATS.
//    With out_ready held high, in_ready returns one cycle later.
//  Inputs are sampled only at acceptance. Changes to vectorA/B/opcode/saturate while BUSY/DONE have no effect.
//  in_ready=0 in BUSY and DONE. No request overlap.
//  out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
//  If in_valid and out_ready are both high in DONE, only the result handshake occurs.
//  Reset (any state, including mid-operation): state=IDLE, beat=0, out_valid=0, result=0, in_ready=1.
//    In-flight work is discarded and no partial result is ever presented.
//  in_ready and out_valid are decoded from registered state only, with no combinational path from inputs.
//  The lane datapath is purely combinational. All state changes occur on clk or on rst_n assertion.
// STRUCTURE
//  Package alu_vec_pkg: opcode_e enum (encoding above), state_e enum {IDLE,BUSY,DONE}.
//  Sub-module alu_vec_lane: combinational, one ELEMENT-wide element op with opcode and saturate.
//    Instantiate LANES copies with a generate loop.
//  Top contains the FSM, beat counter ($clog2(BEATS) bits, minimum 1), operand and result registers, and lane-select muxing.
// TESTING
//  Reset mid-BUSY: accept ADD, assert rst_n=0 at beat 2.
//    Expect out_valid=0, in_ready=1, result=0, and no late out_valid after release.
//  Wrap ADD: all A elems 16'hFFFF, B elems 16'h0002, saturate=0.
//    Expect all result elems 16'h0001. out_valid rises exactly BEATS=4 cycles after accept.
//  Saturation: A=16'h7FF0 with B=16'h0020 under ADD, and A=16'h8000 with B=16'h0001 under SUB, saturate=1.
//    Expect 16'h7FFF and 16'h8000. Same operands with saturate=0 give 16'h8010 and 16'h7FFF.
//  Shift/MUL: SLL A=16'h0001, B=16'h0013 -> 16'h0008. SRL A=16'h8000, B=16'h000F -> 16'h0001.
//    MUL A=16'h0100, B=16'h0101 -> 16'h0100.
//  Backpressure: hold out_ready=0 for 10 cycles in DONE, toggling vectorA/opcode and in_valid.
//    result is stable and in_ready=0 throughout. Single handshake on release.
//  Per-element ordering: A element i = i, B element i = 1, XOR, plus a parameter sweep LANES in {1,4,16}.
//    Every element equals i^1 and latency equals NUM_ELEM/LANES.

Source files
------------

// File: rtl/alu_vec_pkg.sv
// Shared types for the lane-sequenced vector ALU: opcode encoding and FSM states.
package alu_vec_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_MUL = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_vec_lane.sv
// One element-wide ALU lane. Purely combinational; the top instantiates LANES of these
// and time-multiplexes them across the vector.
module alu_vec_lane
  import alu_vec_pkg::*;
#(
  parameter int ELEMENT = 16
) (
  input  logic [ELEMENT-1:0] i_a,
  input  logic [ELEMENT-1:0] i_b,
  input  opcode_e            i_op,
  input  logic               i_sat,
  output logic [ELEMENT-1:0] o_res
);

  localparam int MSB = ELEMENT - 1;
  localparam int SHW = (ELEMENT > 1) ? $clog2(ELEMENT) : 1;
  localparam logic [ELEMENT-1:0] MAX_POS = {1'b0, {(ELEMENT-1){1'b1}}};
  localparam logic [ELEMENT-1:0] MIN_NEG = {1'b1, {(ELEMENT-1){1'b0}}};

  logic [ELEMENT-1:0] w_sum;
  logic [ELEMENT-1:0] w_diff;
  logic               w_addOvf;
  logic               w_subOvf;
  logic [SHW-1:0]     w_shamt;

  assign w_sum   = i_a + i_b;
  assign w_diff  = i_a - i_b;
  // Signed overflow: same-sign operands for add (opposite-sign for sub) producing a result
  // whose sign differs from A. The clamp direction then follows the sign of A.
  assign w_addOvf = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB]  != i_a[MSB]);
  assign w_subOvf = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
  assign w_shamt  = i_b[SHW-1:0];

  // Element operation select; saturation only affects ADD/SUB.
  always_comb begin
    o_res = '0;
    case (i_op)
      OP_ADD:  o_res = (i_sat && w_addOvf) ? (i_a[MSB] ? MIN_NEG : MAX_POS) : w_sum;
      OP_SUB:  o_res = (i_sat && w_subOvf) ? (i_a[MSB] ? MIN_NEG : MAX_POS) : w_diff;
      OP_AND:  o_res = i_a & i_b;
      OP_OR:   o_res = i_a | i_b;
      OP_XOR:  o_res = i_a ^ i_b;
      OP_SLL:  o_res = i_a << w_shamt;
      OP_SRL:  o_res = i_a >> w_shamt;
      OP_MUL:  o_res = i_a * i_b;
      default: o_res = '0;
    endcase
  end

endmodule

// File: rtl/alu_vec_seq.sv
// Lane-sequenced vector ALU top: captures operands on accept, walks LANES elements per
// beat through the lane array into the result register, then holds the result until taken.
module alu_vec_seq
  import alu_vec_pkg::*;
#(
  parameter int VECTOR_SIZE = 256,
  parameter int ELEMENT     = 16,
  parameter int LANES       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [VECTOR_SIZE-1:0] vectorA,
  input  logic [VECTOR_SIZE-1:0] vectorB,
  input  logic [2:0]             opcode,
  input  logic                   saturate,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [VECTOR_SIZE-1:0] result
);

  localparam int NUM_ELEM = VECTOR_SIZE / ELEMENT;
  localparam int BEATS    = NUM_ELEM / LANES;
  localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  // Refuse to elaborate a geometry that does not tile evenly into elements and beats.
  if ((VECTOR_SIZE % ELEMENT) != 0 || (NUM_ELEM % LANES) != 0) begin : g_badParams
    $error("alu_vec_seq: VECTOR_SIZE must be a multiple of ELEMENT and NUM_ELEM a multiple of LANES");
  end

  state_e                 r_state;
  logic [BEAT_W-1:0]      r_beat;
  logic [VECTOR_SIZE-1:0] r_a;
  logic [VECTOR_SIZE-1:0] r_b;
  opcode_e                r_op;
  logic                   r_sat;
  logic [VECTOR_SIZE-1:0] r_result;

  logic [ELEMENT-1:0] w_laneA   [LANES];
  logic [ELEMENT-1:0] w_laneB   [LANES];
  logic [ELEMENT-1:0] w_laneRes [LANES];

  // Steer the current beat's slice of the captured operands onto the lane inputs.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_laneA[l] = r_a[(int'(r_beat) * LANES + l) * ELEMENT +: ELEMENT];
      w_laneB[l] = r_b[(int'(r_beat) * LANES + l) * ELEMENT +: ELEMENT];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    alu_vec_lane #(
      .ELEMENT(ELEMENT)
    ) u_lane (
      .i_a  (w_laneA[l]),
      .i_b  (w_laneB[l]),
      .i_op (r_op),
      .i_sat(r_sat),
      .o_res(w_laneRes[l])
    );
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;

  // Control FSM plus operand capture and per-beat result writeback; reset discards any in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_beat   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_ADD;
      r_sat    <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= vectorA;
            r_b     <= vectorB;
            r_op    <= opcode_e'(opcode);
            r_sat   <= saturate;
            r_beat  <= '0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          for (int l = 0; l < LANES; l++) begin
            r_result[(int'(r_beat) * LANES + l) * ELEMENT +: ELEMENT] <= w_laneRes[l];
          end
          if (r_beat == LAST_BEAT) begin
            r_beat  <= '0;
            r_state <= DONE;
          end else begin
            r_beat <= r_beat + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_vec_seq.sv
// Directed bench for alu_vec_seq: broadcast-vector table, reset mid-operation, backpressure,
// and per-element ordering across LANES = 4, 1 and 16.
module tb_alu_vec_seq;
  import alu_vec_pkg::*;

  localparam int VS = 256;
  localparam int EL = 16;
  localparam int NE = VS / EL;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          inValid;
  logic          outReady;
  logic [VS-1:0] vecA;
  logic [VS-1:0] vecB;
  logic [2:0]    opc;
  logic          sat;
  logic          inReady;
  logic          outValid;
  logic [VS-1:0] res;

  logic          swValid    [2];
  logic          swReady    [2];
  logic          swInReady  [2];
  logic          swOutValid [2];
  logic [VS-1:0] swResult   [2];

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic        sat;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[16];

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  alu_vec_seq #(.VECTOR_SIZE(VS), .ELEMENT(EL), .LANES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady),
    .vectorA(vecA), .vectorB(vecB), .opcode(opc), .saturate(sat),
    .out_valid(outValid), .out_ready(outReady), .result(res)
  );

  alu_vec_seq #(.VECTOR_SIZE(VS), .ELEMENT(EL), .LANES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(swValid[0]), .in_ready(swInReady[0]),
    .vectorA(vecA), .vectorB(vecB), .opcode(opc), .saturate(sat),
    .out_valid(swOutValid[0]), .out_ready(swReady[0]), .result(swResult[0])
  );

  alu_vec_seq #(.VECTOR_SIZE(VS), .ELEMENT(EL), .LANES(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(swValid[1]), .in_ready(swInReady[1]),
    .vectorA(vecA), .vectorB(vecB), .opcode(opc), .saturate(sat),
    .out_valid(swOutValid[1]), .out_ready(swReady[1]), .result(swResult[1])
  );

  function automatic logic [VS-1:0] bcast(input logic [15:0] e);
    logic [VS-1:0] v;
    for (int i = 0; i < NE; i++) v[i*EL +: EL] = e;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [VS-1:0] act, input logic [VS-1:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present a request to the main DUT, confirm it is accepted, and leave #1 after the accept edge.
  task automatic applyStimulus(input logic [VS-1:0] a, input logic [VS-1:0] b,
                               input logic [2:0] op, input logic s);
    vecA    = a;
    vecB    = b;
    opc     = op;
    sat     = s;
    inValid = 1'b1;
    checkOutput("in_ready before accept", {255'b0, inReady}, 1);
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid is seen; -1 if it never arrives.
  task automatic waitOutValid(input int which, output int lat);
    logic ov;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      ov = (which == 0) ? outValid : swOutValid[which-1];
      if (ov) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic releaseResult();
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    checkOutput("out_valid after handshake", {255'b0, outValid}, 0);
    checkOutput("in_ready after handshake", {255'b0, inReady}, 1);
  endtask

  // Main test sequence.
  initial begin
    int            lat;
    int            lateValid;
    logic [VS-1:0] expV;
    logic [VS-1:0] ordA;
    logic [VS-1:0] ordB;
    logic [VS-1:0] ordExp;

    vecs[0]  = '{16'hFFFF, 16'h0002, OP_ADD, 1'b0, 16'h0001};
    vecs[1]  = '{16'h7FF0, 16'h0020, OP_ADD, 1'b1, 16'h7FFF};
    vecs[2]  = '{16'h8000, 16'h0001, OP_SUB, 1'b1, 16'h8000};
    vecs[3]  = '{16'h7FF0, 16'h0020, OP_ADD, 1'b0, 16'h8010};
    vecs[4]  = '{16'h8000, 16'h0001, OP_SUB, 1'b0, 16'h7FFF};
    vecs[5]  = '{16'h0001, 16'h0013, OP_SLL, 1'b0, 16'h0008};
    vecs[6]  = '{16'h8000, 16'h000F, OP_SRL, 1'b0, 16'h0001};
    vecs[7]  = '{16'h0100, 16'h0101, OP_MUL, 1'b0, 16'h0100};
    vecs[8]  = '{16'hF0F0, 16'h3C3C, OP_AND, 1'b0, 16'h3030};
    vecs[9]  = '{16'hF0F0, 16'h0F00, OP_OR,  1'b0, 16'hFFF0};
    vecs[10] = '{16'hAAAA, 16'hFFFF, OP_XOR, 1'b0, 16'h5555};
    vecs[11] = '{16'h0005, 16'h0007, OP_SUB, 1'b0, 16'hFFFE};
    vecs[12] = '{16'hFFFF, 16'h0001, OP_ADD, 1'b1, 16'h0000};
    vecs[13] = '{16'h8000, 16'hFFFF, OP_ADD, 1'b1, 16'h8000};
    vecs[14] = '{16'h7FFF, 16'hFFFF, OP_SUB, 1'b1, 16'h7FFF};
    vecs[15] = '{16'hFFFF, 16'h00FF, OP_AND, 1'b1, 16'h00FF};

    rst_n    = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    vecA     = '0;
    vecB     = '0;
    opc      = '0;
    sat      = 1'b0;
    swValid  = '{1'b0, 1'b0};
    swReady  = '{1'b0, 1'b0};
    #2;
    checkOutput("reset out_valid", {255'b0, outValid}, 0);
    checkOutput("reset in_ready", {255'b0, inReady}, 1);
    checkOutput("reset result", res, '0);
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(bcast(vecs[i].a), bcast(vecs[i].b), vecs[i].op, vecs[i].sat);
      waitOutValid(0, lat);
      checkOutput($sformatf("vec%0d latency", i), VS'(lat), VS'(4));
      checkOutput($sformatf("vec%0d result", i), res, bcast(vecs[i].exp));
      releaseResult();
    end

    $display("[TB] reset during BUSY");
    applyStimulus(bcast(16'h0001), bcast(16'h0001), OP_ADD, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset out_valid", {255'b0, outValid}, 0);
    checkOutput("midreset in_ready", {255'b0, inReady}, 1);
    checkOutput("midreset result", res, '0);
    @(negedge clk);
    rst_n = 1'b1;
    lateValid = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (outValid) lateValid++;
    end
    checkOutput("midreset late out_valid", VS'(lateValid), '0);
    checkOutput("midreset result after release", res, '0);

    $display("[TB] backpressure");
    expV = bcast(16'h0204);
    applyStimulus(bcast(16'h1234), bcast(16'h0F0F), OP_AND, 1'b0);
    waitOutValid(0, lat);
    checkOutput("bp latency", VS'(lat), VS'(4));
    for (int k = 0; k < 10; k++) begin
      vecA    = ~vecA;
      opc     = 3'(k);
      inValid = ~inValid;
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp hold result c%0d", k), res, expV);
      checkOutput($sformatf("bp hold in_ready c%0d", k), {255'b0, inReady}, 0);
      checkOutput($sformatf("bp hold out_valid c%0d", k), {255'b0, outValid}, 1);
    end
    inValid  = 1'b1;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    inValid  = 1'b0;
    outReady = 1'b0;
    checkOutput("bp release out_valid", {255'b0, outValid}, 0);
    checkOutput("bp release in_ready", {255'b0, inReady}, 1);
    lateValid = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (outValid || !inReady) lateValid++;
    end
    checkOutput("bp no second transaction", VS'(lateValid), '0);

    $display("[TB] per-element ordering");
    for (int i = 0; i < NE; i++) begin
      ordA[i*EL +: EL]   = 16'(i);
      ordB[i*EL +: EL]   = 16'h0001;
      ordExp[i*EL +: EL] = 16'(i ^ 1);
    end
    applyStimulus(ordA, ordB, OP_XOR, 1'b0);
    waitOutValid(0, lat);
    checkOutput("order L4 latency", VS'(lat), VS'(4));
    checkOutput("order L4 result", res, ordExp);
    releaseResult();

    for (int k = 0; k < 2; k++) begin
      vecA = ordA;
      vecB = ordB;
      opc  = OP_XOR;
      sat  = 1'b0;
      checkOutput($sformatf("order sweep%0d in_ready", k), {255'b0, swInReady[k]}, 1);
      swValid[k] = 1'b1;
      @(posedge clk);
      #1;
      swValid[k] = 1'b0;
      waitOutValid(k + 1, lat);
      checkOutput($sformatf("order sweep%0d latency", k), VS'(lat), VS'((k == 0) ? 16 : 1));
      checkOutput($sformatf("order sweep%0d result", k), swResult[k], ordExp);
      swReady[k] = 1'b1;
      @(posedge clk);
      #1;
      swReady[k] = 1'b0;
      checkOutput($sformatf("order sweep%0d out_valid after", k), {255'b0, swOutValid[k]}, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
